// File: rtl/xdma_xfer_seq.sv
// ---------------------------------------------------------------------------
// xdma_xfer_seq
//
// Per-channel DMA transfer sequencer placed directly in front of the DMA data
// converter. One descriptor (mode, SRAM start address, beat count) is loaded
// with cfg_start. The sequencer then drives the converter's GIF request side
// one beat at a time and holds dma_mode stable for the whole transfer.
//
//   Write modes (any mode other than 3/4): beats stream from the external-bus
//   read FIFO (in_*) straight into SRAM. mdata/mwstrb are a zero-latency
//   passthrough of in_data/in_strb.
//   Read modes (3 = IOB0->mem, 4 = IOB1->mem): SRAM data returned on sdata is
//   captured into a 1-deep output buffer (out_*) for the external-bus write
//   path.
//
// Ports
//   xclk, xreset_n      clock, asynchronous active-low reset
//   cfg_start           one-cycle pulse, loads the descriptor when idle
//   cfg_mode            DMA mode code
//   cfg_sram_addr       first SRAM word address
//   cfg_len             number of beats (0 = empty transfer)
//   cfg_abort           stop after the current cycle
//   busy, done          transfer in progress / one-cycle completion pulse
//   beat_cnt            beats completed in the current or last transfer
//   in_valid/in_data/in_strb/in_ready   write-mode source beat
//   out_valid/out_data/out_ready        read-mode sink beat
//   dma_mode, maddr_sram_start          registered descriptor to converter
//   maddr, mread, mwrite, mdata, mwstrb GIF request
//   saccept, svalid, sdata, mready      GIF response
// ---------------------------------------------------------------------------
module xdma_xfer_seq #(
    parameter int unsigned DWIDTH = 128,
    parameter int unsigned LENW   = 16
) (
    input  logic                  xclk,
    input  logic                  xreset_n,

    input  logic                  cfg_start,
    input  logic [3:0]            cfg_mode,
    input  logic [31:0]           cfg_sram_addr,
    input  logic [LENW-1:0]       cfg_len,
    input  logic                  cfg_abort,
    output logic                  busy,
    output logic                  done,
    output logic [LENW-1:0]       beat_cnt,

    input  logic                  in_valid,
    input  logic [DWIDTH-1:0]     in_data,
    input  logic [DWIDTH/8-1:0]   in_strb,
    output logic                  in_ready,

    output logic                  out_valid,
    output logic [DWIDTH-1:0]     out_data,
    input  logic                  out_ready,

    output logic [3:0]            dma_mode,
    output logic [31:0]           maddr_sram_start,
    output logic [31:0]           maddr,
    output logic                  mread,
    output logic                  mwrite,
    output logic [DWIDTH-1:0]     mdata,
    output logic [DWIDTH/8-1:0]   mwstrb,
    input  logic                  saccept,
    input  logic                  svalid,
    input  logic [DWIDTH-1:0]     sdata,
    output logic                  mready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [3:0] MODE_IOB0_TO_MEM = 4'd3;
    localparam logic [3:0] MODE_IOB1_TO_MEM = 4'd4;

    state_e               state_q, state_d;
    logic [3:0]           mode_q, mode_d;
    logic [31:0]          sram_start_q, sram_start_d;
    logic [31:0]          maddr_q, maddr_d;
    logic [LENW-1:0]      len_q, len_d;
    logic [LENW-1:0]      beat_cnt_q, beat_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]    out_data_q, out_data_d;
    logic                 done_q, done_d;

    logic                 is_read;
    logic                 last_beat;
    logic                 beat;

    assign is_read   = (mode_q == MODE_IOB0_TO_MEM) || (mode_q == MODE_IOB1_TO_MEM);
    // Only meaningful in RUN, where len_q is known to be non-zero.
    assign last_beat = (beat_cnt_q == (len_q - LENW'(1)));

    // State and datapath registers; everything returns to zero on reset,
    // so an in-flight beat is simply dropped.
    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            sram_start_q <= '0;
            maddr_q      <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sram_start_q <= sram_start_d;
            maddr_q      <= maddr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
        end
    end

    // Next-state and request logic. A beat completes only on a full
    // handshake; without it the request stays up and nothing advances.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        sram_start_d = sram_start_q;
        maddr_d      = maddr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        mread        = 1'b0;
        mwrite       = 1'b0;
        mready       = 1'b0;
        in_ready     = 1'b0;
        beat         = 1'b0;

        // The output buffer drains in any state, so a beat captured just
        // before an abort is still delivered.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    mode_d       = cfg_mode;
                    sram_start_d = cfg_sram_addr;
                    maddr_d      = cfg_sram_addr;
                    len_d        = cfg_len;
                    beat_cnt_d   = '0;
                    state_d      = (cfg_len == '0) ? FIN : RUN;
                end
            end

            RUN: begin
                if (is_read) begin
                    // Request only when the buffer has room this cycle,
                    // either empty or being emptied right now.
                    mread  = ~out_valid_q | out_ready;
                    mready = mread;
                    beat   = mread & saccept & svalid;
                    if (beat) begin
                        out_data_d  = sdata;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    mwrite   = in_valid;
                    mready   = 1'b1;
                    beat     = in_valid & saccept & svalid;
                    in_ready = beat;
                end

                if (beat) begin
                    maddr_d    = maddr_q + 32'd1;
                    beat_cnt_d = beat_cnt_q + LENW'(1);
                end

                if (cfg_abort || (beat && last_beat)) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                // Reads hold off completion until the last beat has left
                // the output buffer.
                if (!(is_read && out_valid_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy             = (state_q == RUN) || (state_q == FIN);
    assign done             = done_q;
    assign beat_cnt         = beat_cnt_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign dma_mode         = mode_q;
    assign maddr_sram_start = sram_start_q;
    assign maddr            = maddr_q;
    assign mdata            = in_data;
    assign mwstrb           = in_strb;

endmodule
